// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: two request channels and the shared response.
// The master modport belongs to the requesters and the slave modport to the arbiter.
interface mem_arbiter_if #(
  parameter int WID_MEM = 32
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_we;
  logic [31:0]        req_addr0;
  logic [31:0]        req_addr1;
  logic [WID_MEM-1:0] req_wdata0;
  logic [WID_MEM-1:0] req_wdata1;
  logic [1:0]         resp_valid;
  logic [1:0]         resp_err;
  logic [WID_MEM-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for two single-word requesters in front of one block RAM, with a
// clear engine. Grant is zero-latency, read data returns one cycle after the transfer.
module mem_arbiter #(
  parameter int                 WID_MEM   = 32,
  parameter int                 DEPTH_MEM = 2048,
  parameter logic [WID_MEM-1:0] CLR_VALUE = '0
) (
  input  logic               clk,
  input  logic               reset,
  mem_arbiter_if.slave       req_bus,
  input  logic               clr_start,
  output logic               clr_busy,
  output logic               clr_done,
  output logic [31:0]        mem_raddr,
  output logic [31:0]        mem_waddr,
  output logic               mem_we,
  output logic [WID_MEM-1:0] mem_din,
  input  logic [WID_MEM-1:0] mem_dout
);
  localparam int CW = $clog2(DEPTH_MEM);

  typedef enum logic {SERVE, CLEAR} state_t;

  state_t       state;
  logic [CW-1:0] cnt;
  logic         last_grant;
  logic         rd_pend;
  logic [1:0]   resp_valid_q;
  logic [1:0]   resp_err_q;

  logic               gnt;
  logic [1:0]         ready;
  logic               xfer;
  logic               xfer_we;
  logic               oob;
  logic [31:0]        addr;
  logic [WID_MEM-1:0] wdata;

  always_comb begin
    gnt = req_bus.req_valid[1];
    if (&req_bus.req_valid)
      gnt = ~last_grant;
    ready = '0;
    // Ready is also held low while reset is asserted, not just in the clocked state.
    if (reset && state == SERVE && !clr_start && |req_bus.req_valid)
      ready[gnt] = 1'b1;
    xfer    = |ready;
    addr    = gnt ? req_bus.req_addr1 : req_bus.req_addr0;
    wdata   = gnt ? req_bus.req_wdata1 : req_bus.req_wdata0;
    xfer_we = req_bus.req_we[gnt];
    oob     = addr >= 32'(DEPTH_MEM);

    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_din   = '0;
    mem_raddr = '0;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = 32'(cnt);
      mem_din   = CLR_VALUE;
    end else if (xfer && !oob) begin
      if (xfer_we) begin
        mem_we    = 1'b1;
        mem_waddr = addr;
        mem_din   = wdata;
      end else begin
        mem_raddr = addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SERVE;
      cnt          <= '0;
      last_grant   <= 1'b1;
      rd_pend      <= 1'b0;
      resp_valid_q <= '0;
      resp_err_q   <= '0;
    end else begin
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      rd_pend      <= 1'b0;
      case (state)
        SERVE: begin
          if (clr_start) begin
            state <= CLEAR;
          end else if (xfer) begin
            last_grant <= gnt;
            if (!xfer_we)
              resp_valid_q[gnt] <= 1'b1;
            if (oob)
              resp_err_q[gnt] <= 1'b1;
            rd_pend <= !xfer_we && !oob;
          end
        end
        CLEAR: begin
          if (cnt == CW'(DEPTH_MEM - 1)) begin
            cnt   <= '0;
            state <= SERVE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= SERVE;
      endcase
    end
  end

  assign req_bus.req_ready  = ready;
  assign req_bus.resp_valid = resp_valid_q;
  assign req_bus.resp_err   = resp_err_q;
  // Out-of-range reads and idle cycles return zero rather than stale RAM output.
  assign req_bus.resp_rdata = rd_pend ? mem_dout : '0;
  assign clr_busy           = (state == CLEAR);
  assign clr_done           = (state == CLEAR) && (cnt == CW'(DEPTH_MEM - 1));
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: block-RAM model, abstract reference memory and arbitration model,
// per-requester scoreboard queues checked by a negedge monitor.
module tb_mem_arbiter;
  localparam int DEPTH = 2048;
  localparam logic [31:0] CLRV = 32'h0;

  logic        clk;
  logic        reset;
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic        mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  mem_arbiter_if #(.WID_MEM(32)) bus ();

  mem_arbiter #(.WID_MEM(32), .DEPTH_MEM(DEPTH), .CLR_VALUE(CLRV)) dut (
    .clk(clk), .reset(reset), .req_bus(bus), .clr_start(clr_start),
    .clr_busy(clr_busy), .clr_done(clr_done), .mem_raddr(mem_raddr),
    .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we && mem_waddr < DEPTH) ram[mem_waddr[10:0]] <= mem_din;
    mem_dout <= ram[mem_raddr[10:0]];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          due;
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] ref_mem [DEPTH];
  int          m_last;
  int          m_clr_left;
  int          cyc;

  // Monitor: responses due this cycle, then the expected effect of this cycle's inputs.
  always @(negedge clk) begin
    exp_t        e;
    bit          have;
    logic [1:0]  v;
    logic [1:0]  exp_rdy;
    int          k;
    logic [31:0] a;
    logic [31:0] d;
    bit          we;
    bit          oob;
    if (!reset) begin
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_resp", {bus.resp_valid, bus.resp_err}, 0);
      chk("rst_rdata", bus.resp_rdata, 0);
      chk("rst_clr", {clr_busy, clr_done}, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", {mem_raddr, mem_waddr}, 0);
      chk("rst_mem_din", mem_din, 0);
      q0.delete();
      q1.delete();
      m_clr_left = 0;
      m_last     = 1;
    end else begin
      for (int r = 0; r < 2; r++) begin
        have = 0;
        if (r == 0 && q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1; end
        if (r == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1; end
        if (have) begin
          chk($sformatf("resp_valid%0d", r), bus.resp_valid[r], e.rd);
          chk($sformatf("resp_err%0d", r), bus.resp_err[r], e.err);
          if (e.rd) chk($sformatf("resp_rdata%0d", r), bus.resp_rdata, e.data);
        end else begin
          chk($sformatf("resp_idle%0d", r), {bus.resp_valid[r], bus.resp_err[r]}, 0);
        end
      end
      if (bus.resp_valid == 2'b00) chk("rdata_idle", bus.resp_rdata, 0);

      if (m_clr_left > 0) begin
        k = DEPTH - m_clr_left;
        chk("clr_busy", clr_busy, 1);
        chk("clr_done", clr_done, (m_clr_left == 1));
        chk("clr_ready", bus.req_ready, 0);
        chk("clr_write", {mem_we, mem_waddr, mem_din}, {1'b1, k[31:0], CLRV});
        ref_mem[k] = CLRV;
        m_clr_left--;
      end else begin
        chk("idle_clr", {clr_busy, clr_done}, 0);
        if (clr_start) begin
          chk("start_ready", bus.req_ready, 0);
          chk("start_mem_we", mem_we, 0);
          m_clr_left = DEPTH;
        end else begin
          v = bus.req_valid;
          if (v == 2'b11) exp_rdy = (m_last == 0) ? 2'b10 : 2'b01;
          else            exp_rdy = v;
          chk("req_ready", bus.req_ready, exp_rdy);
          if (exp_rdy != 2'b00) begin
            k      = exp_rdy[1] ? 1 : 0;
            m_last = k;
            a      = (k == 1) ? bus.req_addr1 : bus.req_addr0;
            d      = (k == 1) ? bus.req_wdata1 : bus.req_wdata0;
            we     = bus.req_we[k];
            oob    = (a >= DEPTH);
            if (we && !oob) begin
              chk("wr_port", {mem_we, mem_waddr, mem_din}, {1'b1, a, d});
              ref_mem[a] = d;
            end else begin
              chk("no_mem_we", mem_we, 0);
            end
            if (!we && !oob) chk("rd_addr", mem_raddr, a);
            if (!we || oob) begin
              e.due  = cyc + 1;
              e.err  = oob;
              e.rd   = !we;
              e.data = oob ? 32'h0 : ref_mem[a];
              if (k == 0) q0.push_back(e);
              else        q1.push_back(e);
            end
          end else begin
            chk("idle_mem_we", mem_we, 0);
          end
        end
      end
    end
    cyc++;
  end

  task automatic issue(input int k, input bit we, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 0;
    bus.req_we[k] = we;
    if (k == 0) begin bus.req_addr0 = a; bus.req_wdata0 = d; end
    else        begin bus.req_addr1 = a; bus.req_wdata1 = d; end
    bus.req_valid[k] = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready[k]) ok = 1;
    end
    chk("accept_timeout", ok, 1);
    @(posedge clk);
    #1;
    bus.req_valid[k] = 1'b0;
  endtask

  task automatic rand_traffic(input int k, input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) a = DEPTH + $urandom_range(0, 5000);
      else                           a = $urandom_range(0, 15);
      issue(k, 1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) begin ram[i] = 32'h0; ref_mem[i] = 32'h0; end
    cyc = 0; m_last = 1; m_clr_left = 0;
    reset = 1'b0; clr_start = 1'b0;
    bus.req_valid = '0; bus.req_we = '0;
    bus.req_addr0 = '0; bus.req_addr1 = '0;
    bus.req_wdata0 = '0; bus.req_wdata1 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    issue(0, 1'b1, 32'd5, 32'hDEADBEEF);
    issue(0, 1'b0, 32'd5, 32'h0);

    issue(0, 1'b1, 32'd1, 32'h11);
    issue(1, 1'b1, 32'd2, 32'h22);
    fork
      for (int i = 0; i < 8; i++) issue(0, 1'b0, 32'd1, 32'h0);
      for (int j = 0; j < 8; j++) issue(1, 1'b0, 32'd2, 32'h0);
    join

    issue(1, 1'b0, 32'd2048, 32'h0);
    issue(0, 1'b1, 32'd2048, 32'hBAD0BAD0);

    fork
      issue(0, 1'b1, 32'd7, 32'hA5A5_5A5A);
      begin @(posedge clk); #1; issue(1, 1'b0, 32'd7, 32'h0); end
    join

    // Clear requested while requester 0 is already presenting a read of address 0.
    bus.req_we[0] = 1'b0; bus.req_addr0 = 32'd0; bus.req_valid[0] = 1'b1;
    clr_start = 1'b1;
    @(posedge clk); #1 clr_start = 1'b0;
    n = 0;
    while (n < 2100) begin
      @(negedge clk);
      n++;
      if (bus.req_ready[0]) break;
    end
    chk("clr_accept_cycle", n, 2049);
    @(posedge clk); #1 bus.req_valid[0] = 1'b0;
    issue(0, 1'b0, 32'd1000, 32'h0);
    issue(1, 1'b0, 32'd2047, 32'h0);

    issue(0, 1'b1, 32'd99, 32'h9999);
    issue(0, 1'b1, 32'd100, 32'h1001);
    issue(1, 1'b1, 32'd200, 32'h2002);
    clr_start = 1'b1;
    @(posedge clk); #1 clr_start = 1'b0;
    repeat (100) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    issue(0, 1'b0, 32'd99, 32'h0);
    issue(1, 1'b0, 32'd100, 32'h0);
    issue(0, 1'b0, 32'd200, 32'h0);

    fork
      rand_traffic(0, 150);
      rand_traffic(1, 150);
    join

    repeat (5) @(posedge clk);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter and clear sequencer in front of a single block-RAM memory (one read port, one write port, registered read data, one-cycle read latency). Each requester issues single-word read or write transactions over a valid/ready handshake; the arbiter grants at most one transaction per cycle, drives the memory ports and returns read data with a per-requester response strobe. A built-in clear engine overwrites the whole array with a fixed value on command, locking out requesters while it runs.

## Interface
- WID_MEM, 32, data word width
- DEPTH_MEM, 2048, number of words; legal addresses 0..DEPTH_MEM-1
- CLR_VALUE, 0, word written to every location by the clear engine
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (assert 0 = reset)
- req_valid  in  2  per-requester request valid (bit k = requester k)
- req_ready  out  2  per-requester accept; transfer when valid&ready
- req_we  in  2  1 = write, 0 = read
- req_addr0, req_addr1  in  32  word address
- req_wdata0, req_wdata1  in  WID_MEM  write data
- resp_valid  out  2  one-cycle read-data strobe per requester
- resp_rdata  out  WID_MEM  read data, shared, qualified by resp_valid
- resp_err  out  2  one-cycle strobe: accepted request had address >= DEPTH_MEM
- clr_start  in  1  pulse: begin clearing the array
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse at clear completion
- mem_raddr  out  32  memory read address
- mem_waddr  out  32  memory write address
- mem_we  out  1  memory write enable
- mem_din  out  WID_MEM  memory write data
- mem_dout  in  WID_MEM  memory registered read data

## Operation
- States: SERVE, CLEAR. Reset → SERVE.
- SERVE: if clr_start=1 → CLEAR, no request accepted that cycle. Else arbitrate.
- Arbitration: one valid → granted. Both valid → requester ≠ last_grant. last_grant updates only on a transfer. Reset value last_grant=1 (requester 0 wins first tie).
- req_ready is combinational: bit k = (state==SERVE) & !clr_start & grant==k. Requesters hold valid and fields stable until ready.
- Granted write, in-range: mem_we=1, mem_waddr=addr, mem_din=wdata in the grant cycle.
- Granted read, in-range: mem_raddr=addr in the grant cycle; resp_valid[k]=1 next cycle, resp_rdata=mem_dout.
- Out-of-range (addr >= DEPTH_MEM): accepted, mem_we=0, no memory access; resp_err[k]=1 next cycle; for reads also resp_valid[k]=1 with resp_rdata=0.
- mem_we=0 whenever no write transfer or clear write occurs.
- CLEAR: counter 0..DEPTH_MEM-1, one write per cycle (mem_we=1, mem_waddr=counter, mem_din=CLR_VALUE). After writing DEPTH_MEM-1: clr_done=1 for one cycle, → SERVE, counter reset to 0. clr_start during CLEAR ignored. clr_busy=1 exactly while in CLEAR.
- Reset mid-clear: immediate return to SERVE, counter 0, no clr_done; memory left partially cleared.

## Timing
- Reset values: req_ready=0 (state SERVE but combinational term still 0 during reset), resp_valid=0, resp_err=0, resp_rdata=0 when resp_valid=0, clr_busy=0, clr_done=0, mem_we=0, mem_raddr=0, mem_waddr=0, mem_din=0.
- Throughput: one transfer per cycle sustained; alternating grants when both requesters continuously valid.
- Read latency: transfer at cycle T → resp_valid at T+1.
- Write then read same address in consecutive cycles: read returns new data (write committed at end of T).
- Clear: clr_start at T → clr_busy 1 from T+1 for DEPTH_MEM cycles; clr_done in cycle T+DEPTH_MEM; first request accepted in T+DEPTH_MEM+1 at earliest.
- resp_valid/resp_err are registered outputs; req_ready, mem_* are combinational from state and requests.

## Test plan
- Reset, then req0 write addr 5 data 0xDEADBEEF, then req0 read addr 5 → resp_valid=01 one cycle after read transfer, resp_rdata=0xDEADBEEF.
- Both requesters read continuously (addr 1 and 2 preloaded 0x11, 0x22) → grants 0,1,0,1…; responses alternate 0x11/0x22, one per cycle.
- req1 read addr 2048 → accepted, resp_valid=10, resp_err=10, resp_rdata=0, no mem_we.
- clr_start with req0 valid in same cycle → req_ready=00, clr_busy high 2048 cycles, clr_done one pulse, then req0 accepted; reads of addr 0, 1000, 2047 return CLR_VALUE.
- Assert reset at clear counter 100 → clr_busy=0 immediately, no clr_done; addr 99 reads CLR_VALUE, addr 200 keeps prior data.
- Write addr 7 cycle T (req0), read addr 7 cycle T+1 (req1) → req1 gets new data.
